// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Constants shared by decode, execute and the hazard scoreboard.
//   FWD_* : bypass-select encoding (0 = regfile, 1 = WB latch, 2 = MEM latch).
//   *_DEF : default pipeline latencies and widths of the 5-stage core.
//   fwd_limit() : largest remaining count at which a producer can be bypassed.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int FWD_RF          = 0;
   localparam int FWD_WB          = 1;
   localparam int FWD_MEM         = 2;

   localparam int REG_ADDR_W      = 5;
   localparam int NUM_REGS_DEF    = 32;
   localparam int WB_LAT_DEF      = 3;
   localparam int ALU_FWD_MAX_DEF = 2;
   localparam int LD_FWD_MAX_DEF  = 1;
   localparam int CNT_W_DEF       = 2;
   localparam int PERF_W_DEF      = 32;

   // Load data only exists from WB onwards, so loads have a tighter window.
   function automatic int fwd_limit(input logic is_load, input int alu_max, input int ld_max);
      return is_load ? ld_max : alu_max;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// ---------------------------------------------------------------------------
// sb_entry
//   Countdown-to-writeback state of one architectural register.
//   clk, reset  : clock / asynchronous active-high clear
//   load_i      : an instruction writing this register issues this cycle
//   is_load_i   : that instruction is a load
//   cnt_o       : cycles remaining until the regfile write (0 = idle)
//   ld_o        : the pending producer is a load
// ---------------------------------------------------------------------------
module sb_entry
   import cpu_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int WB_LAT = WB_LAT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             is_load_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ld_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_q, ld_d;

   always_comb begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      // A new writer overrides the running countdown; latency is uniform,
      // so the newest writer is always the last one to reach the regfile.
      if (load_i) begin
         cnt_d = CNT_W'(WB_LAT);
         ld_d  = is_load_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         ld_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ld_q  <= ld_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ld_o  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   RAW hazard detection and ID-stage bypass selection for the in-order core.
//   Inputs : clk, reset (async, active-high), ID instruction fields
//            (id_valid_i, rs1/rs2 address+used, rd_addr_i, rf_w_en_i,
//            is_load_i) and flush_i.
//   Outputs: stall_o / issue_o (combinational, same cycle),
//            fwd1_sel_o / fwd2_sel_o (0 = regfile, k = stage with count k),
//            busy_o (per-register pending bit), stall_cycles_o (saturating).
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NUM_REGS    = cpu_pkg::NUM_REGS_DEF,
   parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
   parameter int WB_LAT      = cpu_pkg::WB_LAT_DEF,
   parameter int ALU_FWD_MAX = cpu_pkg::ALU_FWD_MAX_DEF,
   parameter int LD_FWD_MAX  = cpu_pkg::LD_FWD_MAX_DEF,
   parameter int CNT_W       = cpu_pkg::CNT_W_DEF,
   parameter int PERF_W      = cpu_pkg::PERF_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic                  rs1_used_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   input  logic                  rs2_used_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  rf_w_en_i,
   input  logic                  is_load_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  issue_o,
   output logic [CNT_W-1:0]      fwd1_sel_o,
   output logic [CNT_W-1:0]      fwd2_sel_o,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic [PERF_W-1:0]     stall_cycles_o
);

   import cpu_pkg::*;

   logic [CNT_W-1:0]  cnt_arr [NUM_REGS];
   logic              ld_arr  [NUM_REGS];
   logic              wr_en;
   logic              hazard_any;
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

   // x0 is hard-wired to zero and never has a pending producer.
   assign cnt_arr[0] = '0;
   assign ld_arr[0]  = 1'b0;

   assign wr_en = issue_o && rf_w_en_i && (rd_addr_i != '0);

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      sb_entry #(
         .CNT_W  (CNT_W),
         .WB_LAT (WB_LAT)
      ) u_entry (
         .clk       (clk),
         .reset     (reset),
         .load_i    (wr_en && (rd_addr_i == REG_ADDR_W'(gi))),
         .is_load_i (is_load_i),
         .cnt_o     (cnt_arr[gi]),
         .ld_o      (ld_arr[gi])
      );
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_o[gi] = (cnt_arr[gi] != '0);
   end

   // Source checks look only at the registered state, so an instruction
   // issuing this cycle can never satisfy its own operands.
   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] addr;
      logic                  used;
      logic [CNT_W-1:0]      cnt;
      logic                  ld;
      logic [CNT_W-1:0]      sel;
      logic                  haz;

      assign addr = (gi == 0) ? rs1_addr_i : rs2_addr_i;
      assign used = (gi == 0) ? rs1_used_i : rs2_used_i;
      assign cnt  = cnt_arr[addr];
      assign ld   = ld_arr[addr];

      always_comb begin
         sel = CNT_W'(FWD_RF);
         haz = 1'b0;
         if (id_valid_i && used && (addr != '0) && (cnt != '0)) begin
            if (int'(cnt) <= fwd_limit(ld, ALU_FWD_MAX, LD_FWD_MAX)) begin
               sel = cnt;
            end else begin
               haz = 1'b1;
            end
         end
      end
   end

   assign fwd1_sel_o = g_src[0].sel;
   assign fwd2_sel_o = g_src[1].sel;

   // Flush squashes the ID instruction, so it neither stalls nor issues.
   assign hazard_any = g_src[0].haz || g_src[1].haz;
   assign stall_o    = hazard_any && !flush_i;
   assign issue_o    = id_valid_i && !stall_o && !flush_i;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_o && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rs1_used, rs2_used, rf_w_en, is_load, flush;

   logic        stall, issue;
   logic [1:0]  sel1, sel2;
   logic [31:0] busy;
   logic [31:0] perf;

   logic        s_stall, s_issue;
   logic [1:0]  s_sel1, s_sel2;
   logic [31:0] s_busy;
   logic [3:0]  s_perf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset), .id_valid_i(id_valid),
      .rs1_addr_i(rs1_addr), .rs1_used_i(rs1_used),
      .rs2_addr_i(rs2_addr), .rs2_used_i(rs2_used),
      .rd_addr_i(rd_addr), .rf_w_en_i(rf_w_en), .is_load_i(is_load),
      .flush_i(flush), .stall_o(stall), .issue_o(issue),
      .fwd1_sel_o(sel1), .fwd2_sel_o(sel2), .busy_o(busy),
      .stall_cycles_o(perf)
   );

   hazard_scoreboard #(.PERF_W(4)) dut_sat (
      .clk(clk), .reset(reset), .id_valid_i(id_valid),
      .rs1_addr_i(rs1_addr), .rs1_used_i(rs1_used),
      .rs2_addr_i(rs2_addr), .rs2_used_i(rs2_used),
      .rd_addr_i(rd_addr), .rf_w_en_i(rf_w_en), .is_load_i(is_load),
      .flush_i(flush), .stall_o(s_stall), .issue_o(s_issue),
      .fwd1_sel_o(s_sel1), .fwd2_sel_o(s_sel2), .busy_o(s_busy),
      .stall_cycles_o(s_perf)
   );

   // Reference model: each register remembers the absolute cycle of its
   // regfile write; remaining latency is that cycle minus the current one.
   int cyc = 0;
   int wb_at [32];
   bit m_ld  [32];
   int m_perf = 0;

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         wb_at[r] = 0;
         m_ld[r]  = 1'b0;
      end
      m_perf = 0;
   endtask

   function automatic int model_rem(input int r);
      if (r == 0 || wb_at[r] <= cyc) return 0;
      return wb_at[r] - cyc;
   endfunction

   function automatic int model_sel(input bit used, input int addr, output bit haz);
      int rem;
      haz = 1'b0;
      if (!id_valid || !used || addr == 0) return 0;
      rem = model_rem(addr);
      if (rem == 0) return 0;
      if (rem <= (m_ld[addr] ? 1 : 2)) return rem;
      haz = 1'b1;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit fl);
      id_valid = v;
      rs1_addr = 5'(r1);
      rs1_used = u1;
      rs2_addr = 5'(r2);
      rs2_used = u2;
      rd_addr  = 5'(rd);
      rf_w_en  = we;
      is_load  = ld;
      flush    = fl;
   endtask

   // Called at the negative edge: compare against the model, then advance
   // the model across the next rising edge.
   task automatic model_cycle();
      bit h1, h2, e_st, e_is;
      int e1, e2, e_sat;
      logic [31:0] e_busy;
      e1 = model_sel(rs1_used, int'(rs1_addr), h1);
      e2 = model_sel(rs2_used, int'(rs2_addr), h2);
      e_st = (h1 || h2) && !flush;
      e_is = id_valid && !e_st && !flush;
      for (int r = 0; r < 32; r++) e_busy[r] = (model_rem(r) > 0);
      e_sat = (m_perf > 15) ? 15 : m_perf;
      chk("stall", 64'(stall), 64'(e_st));
      chk("issue", 64'(issue), 64'(e_is));
      chk("fwd1_sel", 64'(sel1), 64'(e1));
      chk("fwd2_sel", 64'(sel2), 64'(e2));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("stall_cycles", 64'(perf), 64'(m_perf));
      chk("sat_stall", 64'(s_stall), 64'(e_st));
      chk("sat_stall_cycles", 64'(s_perf), 64'(e_sat));
      chk("sat_busy", 64'(s_busy ^ busy), 64'(0));
      chk("sat_sel", 64'({s_sel1, s_sel2, s_issue}), 64'({sel1, sel2, issue}));
      @(posedge clk);
      if (!reset) begin
         if (e_st) m_perf++;
         cyc++;
         if (e_is && rf_w_en && rd_addr != 0) begin
            wb_at[rd_addr] = cyc + 3;
            m_ld[rd_addr]  = is_load;
         end
      end
      #1;
   endtask

   typedef struct {
      bit v; int r1; bit u1; int r2; bit u2; int rd; bit we; bit ld; bit fl;
      bit e_st; bit e_is; int e_s1; int e_s2; logic [31:0] e_busy; int e_perf;
   } vec_t;

   vec_t vecs [15];

   initial begin
      // ALU RAW on x5, load-use on x6, x0 / unused sources, flush, WAW on x7.
      vecs[0]  = '{1,  0, 0, 0, 0,  5, 1, 0, 0,  0, 1, 0, 0, 32'h000, 0};
      vecs[1]  = '{1,  5, 1, 0, 0,  8, 1, 0, 0,  1, 0, 0, 0, 32'h020, 0};
      vecs[2]  = '{1,  5, 1, 0, 0,  8, 1, 0, 0,  0, 1, 2, 0, 32'h020, 1};
      vecs[3]  = '{1,  0, 0, 0, 0,  6, 1, 1, 0,  0, 1, 0, 0, 32'h120, 1};
      vecs[4]  = '{1,  0, 0, 6, 1,  9, 1, 0, 0,  1, 0, 0, 0, 32'h140, 1};
      vecs[5]  = '{1,  0, 0, 6, 1,  9, 1, 0, 0,  1, 0, 0, 0, 32'h140, 2};
      vecs[6]  = '{1,  0, 0, 6, 1,  9, 1, 0, 0,  0, 1, 0, 1, 32'h040, 3};
      vecs[7]  = '{1,  0, 1, 9, 0,  0, 1, 0, 0,  0, 1, 0, 0, 32'h200, 3};
      vecs[8]  = '{1,  0, 1, 0, 0, 10, 1, 0, 0,  0, 1, 0, 0, 32'h200, 3};
      vecs[9]  = '{1, 10, 1, 0, 0, 11, 1, 0, 1,  0, 0, 0, 0, 32'h600, 3};
      vecs[10] = '{1, 10, 1, 0, 0,  7, 1, 0, 0,  0, 1, 2, 0, 32'h400, 3};
      vecs[11] = '{1,  0, 0, 0, 0,  7, 1, 1, 0,  0, 1, 0, 0, 32'h480, 3};
      vecs[12] = '{1,  7, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 32'h080, 3};
      vecs[13] = '{1,  7, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 32'h080, 4};
      vecs[14] = '{1,  7, 1, 0, 0,  0, 0, 0, 0,  0, 1, 1, 0, 32'h080, 5};

      model_clear();
      reset = 1'b1;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_stall_cycles", 64'(perf), 64'(0));
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].v, vecs[i].r1, vecs[i].u1, vecs[i].r2, vecs[i].u2,
               vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].fl);
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].e_st));
         chk($sformatf("vec%0d_issue", i), 64'(issue), 64'(vecs[i].e_is));
         chk($sformatf("vec%0d_fwd1", i), 64'(sel1), 64'(vecs[i].e_s1));
         chk($sformatf("vec%0d_fwd2", i), 64'(sel2), 64'(vecs[i].e_s2));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
         chk($sformatf("vec%0d_perf", i), 64'(perf), 64'(vecs[i].e_perf));
         model_cycle();
      end

      // Asynchronous reset while x5 has cnt = 3 and a dependent sits in ID
      apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
      @(negedge clk);
      model_cycle();
      apply(1, 5, 1, 0, 0, 0, 0, 0, 0);
      #2;
      chk("pre_reset_busy5", 64'(busy[5]), 64'(1));
      chk("pre_reset_stall", 64'(stall), 64'(1));
      reset = 1'b1;
      #1;
      chk("async_reset_busy", 64'(busy), 64'(0));
      chk("async_reset_stall", 64'(stall), 64'(0));
      chk("async_reset_perf", 64'(perf), 64'(0));
      chk("async_reset_sat_perf", 64'(s_perf), 64'(0));
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Ten load-use pairs: 20 stall cycles, 4-bit counter stops at 15
      for (int k = 0; k < 10; k++) begin
         apply(1, 0, 0, 0, 0, 6, 1, 1, 0);
         @(negedge clk);
         model_cycle();
         for (int j = 0; j < 3; j++) begin
            apply(1, 0, 0, 6, 1, 0, 0, 0, 0);
            @(negedge clk);
            model_cycle();
         end
      end
      chk("load_use_perf20", 64'(perf), 64'(20));
      chk("saturated_perf15", 64'(s_perf), 64'(15));

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         apply(($urandom % 4) != 0, $urandom_range(0, 7), $urandom % 2,
               $urandom_range(0, 7), $urandom % 2, $urandom_range(0, 7),
               ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
         @(negedge clk);
         model_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
